issue_scoreboard: RTL and testbench
===================================

# issue_scoreboard

Parametrised successor to the decode-stage hazard detector. It tracks pending register writes with per-register countdown counters instead of comparing against fixed pipeline-stage tags. It supports an optional forwarding mode, in which only load-use stalls remain, and a programmable control-shadow length. It sits between fetch/decode and the execute stage: it decides each cycle whether the decoded instruction issues or is replaced by a NOP bubble while the PC is held.

## Interface
Parameters:
- NREG, 8, number of architectural registers
- RIDX, 3, register index width; must equal clog2(NREG)
- WB_LAT, 3, cycles from issue until the result is readable from the register file; range 1..15
- CTRL_SHADOW, 4, cycles issue is blocked after a control instruction issues; range 0..15
- FWD_EN, 0, 1 = X/M forwarding present, so results are usable before writeback

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- dec_valid  in  1  a decoded instruction is presented
- dec_rs_idx  in  RIDX  first source register
- dec_rs_use  in  1  instruction reads rs
- dec_rt_idx  in  RIDX  second source register (rt, or rd for stores)
- dec_rt_use  in  1  instruction reads rt
- dec_wr_idx  in  RIDX  destination register
- dec_wr_en  in  1  instruction writes a register
- dec_is_load  in  1  destination value comes from memory
- dec_is_ctrl  in  1  jump or branch
- dec_is_halt  in  1  HALT instruction
- issue  out  1  instruction advances to execute this cycle
- stall  out  1  hold PC and the fetch/decode register
- inject_nop  out  1  drive NOP (opcode 00001) into execute
- halted  out  1  HALT has issued
- stall_cycles  out  16  saturating count of stalled valid cycles

## Operation
State:
- cnt[NREG], each CW = clog2(WB_LAT+1) bits.
- ld[NREG], 1 bit each.
- shadow, 4 bits.
- halted, 1 bit.
- stall_cycles, 16 bits.

Per-register ready threshold thr[r]:
- FWD_EN=0: thr[r] = 0.
- FWD_EN=1 and ld[r]=0: thr[r] = WB_LAT.
- FWD_EN=1 and ld[r]=1: thr[r] = WB_LAT-1.

Hazard and control decisions (combinational):
- raw = (dec_rs_use & cnt[rs] > thr[rs]) | (dec_rt_use & cnt[rt] > thr[rt]).
- block = halted | (shadow != 0) | raw.
- issue = dec_valid & ~block.
- stall = dec_valid & block.
- inject_nop = ~issue.

Sequential updates on each rising clk edge:
- Every nonzero cnt decrements by 1.
- If issue & dec_wr_en: cnt[wr] <= WB_LAT and ld[wr] <= dec_is_load. This load overrides the decrement for that register (WAW simply reloads the counter).
- If issue & dec_is_ctrl: shadow <= CTRL_SHADOW. Otherwise shadow decrements when nonzero.
- If issue & dec_is_halt: halted <= 1. It stays set until reset.
- If stall & ~halted: stall_cycles increments, saturating at 16'hFFFF.

Rules:
- Source checks use the pre-update counters, so an instruction that reads and writes the same register checks the older producer.
- No register is hardwired to zero.
- dec_valid=0 gives issue=0, stall=0, inject_nop=1, and no state change other than the decrements.

## Timing
- Reset (rst=0, asynchronous): all cnt, ld, shadow, halted, stall_cycles = 0. With all state clear, outputs follow the combinational rules: issue=dec_valid, stall=0, inject_nop=~dec_valid.
- issue, stall and inject_nop are combinational from the dec_* inputs and registered state within the same cycle. There are no registered outputs apart from halted and stall_cycles.
- Stall penalty for a consumer following its producer by one issue slot:
  - FWD_EN=0: WB_LAT cycles.
  - FWD_EN=1, ALU producer: 0 cycles.
  - FWD_EN=1, load producer: 1 cycle.
- Control shadow: a control instruction issued at cycle t blocks cycles t+1 .. t+CTRL_SHADOW. Issue resumes at t+CTRL_SHADOW+1.
- Shadow and raw overlap: the stall ends only when both clear. Both conditions count as a single stall cycle.
- rst asserted mid-stall: the stall releases immediately and the counters are not preserved.

## Test plan
- FWD_EN=0, WB_LAT=3: ADD r1 issued at t, then SUB reading r1 held valid -> stall=1 at t+1..t+3, issue=1 at t+4; stall_cycles=3.
- FWD_EN=1, WB_LAT=3: ADD r2 then a dependent reader -> issue=1 at t+1, no stall. LD r2 then a dependent reader -> 1 stall cycle, issue at t+2.
- CTRL_SHADOW=4: BEQZ issues at t with a non-dependent instruction waiting -> inject_nop=1 at t+1..t+4, issue at t+5.
- WAW plus self-dependence: ADD r3 at t, ADD r3,r3 at t+1 (FWD_EN=0) -> stall until cnt[r3]=0 at t+4. After it issues, cnt[r3] reloads to 3.
- HALT issues at t -> halted=1 from t+1. Every later valid instruction gets stall=1 and issue=0, and stall_cycles stays frozen.
- Async reset mid-stall: pull rst low between clock edges -> cnt and shadow clear immediately, stall drops, and stall_cycles reads 0.

Source files
------------

// File: rtl/issue_scoreboard_if.sv
// Decode-to-issue handshake between the decoder and the issue scoreboard.
interface issue_scoreboard_if #(
    parameter int RIDX = 3
);
    logic            dec_valid;
    logic [RIDX-1:0] dec_rs_idx;
    logic            dec_rs_use;
    logic [RIDX-1:0] dec_rt_idx;
    logic            dec_rt_use;
    logic [RIDX-1:0] dec_wr_idx;
    logic            dec_wr_en;
    logic            dec_is_load;
    logic            dec_is_ctrl;
    logic            dec_is_halt;
    logic            issue;
    logic            stall;
    logic            inject_nop;
    logic            halted;
    logic [15:0]     stall_cycles;

    modport master (
        output dec_valid, dec_rs_idx, dec_rs_use, dec_rt_idx, dec_rt_use,
               dec_wr_idx, dec_wr_en, dec_is_load, dec_is_ctrl, dec_is_halt,
        input  issue, stall, inject_nop, halted, stall_cycles
    );

    modport slave (
        input  dec_valid, dec_rs_idx, dec_rs_use, dec_rt_idx, dec_rt_use,
               dec_wr_idx, dec_wr_en, dec_is_load, dec_is_ctrl, dec_is_halt,
        output issue, stall, inject_nop, halted, stall_cycles
    );
endinterface

// File: rtl/issue_scoreboard.sv
// Issue scoreboard: per-register countdown of pending writes, optional
// forwarding thresholds, control shadow and HALT latch. Decides each cycle
// whether the decoded instruction issues or a NOP bubble is injected.
module issue_scoreboard #(
    parameter int NREG        = 8,
    parameter int RIDX        = 3,
    parameter int WB_LAT      = 3,
    parameter int CTRL_SHADOW = 4,
    parameter int FWD_EN      = 0
) (
    input  logic               clk,
    input  logic               rst,
    issue_scoreboard_if.slave  bus
);
    localparam int CW = $clog2(WB_LAT + 1);
    localparam logic [CW-1:0] LAT = CW'(WB_LAT);
    localparam logic [3:0] SHADOW_LEN = 4'(CTRL_SHADOW);

    logic [CW-1:0]   cnt [NREG];
    logic [NREG-1:0] ld;
    logic [3:0]      shadow;
    logic            haltedQ;
    logic [15:0]     stallCnt;

    logic [CW-1:0]   thrRs;
    logic [CW-1:0]   thrRt;
    logic            raw;
    logic            block;
    logic            doIssue;
    logic            doStall;

    // With forwarding a result is usable once it leaves execute (ALU) or
    // memory (load); without it only after writeback.
    function automatic logic [CW-1:0] threshold(input logic isLoad);
        if (FWD_EN == 0)
            return '0;
        else if (isLoad)
            return LAT - CW'(1);
        else
            return LAT;
    endfunction

    // Hazard detection against pre-update counters and issue/stall decision.
    always_comb begin
        thrRs   = threshold(ld[bus.dec_rs_idx]);
        thrRt   = threshold(ld[bus.dec_rt_idx]);
        raw     = (bus.dec_rs_use && (cnt[bus.dec_rs_idx] > thrRs)) ||
                  (bus.dec_rt_use && (cnt[bus.dec_rt_idx] > thrRt));
        block   = haltedQ || (shadow != '0) || raw;
        doIssue = bus.dec_valid && !block;
        doStall = bus.dec_valid && block;
    end

    assign bus.issue        = doIssue;
    assign bus.stall        = doStall;
    assign bus.inject_nop   = !doIssue;
    assign bus.halted       = haltedQ;
    assign bus.stall_cycles = stallCnt;

    // Pending-write counters: a new producer reloads its destination,
    // taking priority over the decrement (covers WAW).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned r = 0; r < NREG; r++) cnt[r] <= '0;
            ld <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (doIssue && bus.dec_wr_en && (bus.dec_wr_idx == RIDX'(r))) begin
                    cnt[r] <= LAT;
                    ld[r]  <= bus.dec_is_load;
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
        end
    end

    // Control shadow countdown, HALT latch and saturating stall counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow   <= '0;
            haltedQ  <= 1'b0;
            stallCnt <= '0;
        end else begin
            if (doIssue && bus.dec_is_ctrl)
                shadow <= SHADOW_LEN;
            else if (shadow != '0)
                shadow <= shadow - 4'd1;
            if (doIssue && bus.dec_is_halt)
                haltedQ <= 1'b1;
            if (doStall && !haltedQ && (stallCnt != '1))
                stallCnt <= stallCnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_issue_scoreboard.sv
// Scoreboard bench: stimulus pushes the hand-computed expected outputs for each
// driven cycle; a monitor pops and compares on the falling edge.
module tb_issue_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    issue_scoreboard_if #(.RIDX(3)) ifA ();
    issue_scoreboard_if #(.RIDX(3)) ifB ();

    issue_scoreboard #(.NREG(8), .RIDX(3), .WB_LAT(3), .CTRL_SHADOW(4), .FWD_EN(0))
        dutA (.clk(clk), .rst(rst), .bus(ifA));
    issue_scoreboard #(.NREG(8), .RIDX(3), .WB_LAT(3), .CTRL_SHADOW(4), .FWD_EN(1))
        dutB (.clk(clk), .rst(rst), .bus(ifB));

    typedef struct {
        int          id;
        logic [19:0] v;   // {issue, stall, inject_nop, halted, stall_cycles}
    } exp_t;

    exp_t qA[$];
    exp_t qB[$];
    int   nChecks = 0;
    int   nFail   = 0;
    int   stepId  = 0;

    task automatic compare(input string tag, input exp_t e, input logic [19:0] got);
        nChecks++;
        if (got !== e.v) begin
            nFail++;
            $display("FAIL %s step %0d: got issue=%b stall=%b nop=%b halted=%b cycles=%0d, required issue=%b stall=%b nop=%b halted=%b cycles=%0d",
                     tag, e.id, got[19], got[18], got[17], got[16], got[15:0],
                     e.v[19], e.v[18], e.v[17], e.v[16], e.v[15:0]);
        end
    endtask

    // Monitor: one expected record per driven cycle, checked mid-cycle.
    always @(negedge clk) begin
        if (qA.size() > 0)
            compare("dutA", qA.pop_front(),
                    {ifA.issue, ifA.stall, ifA.inject_nop, ifA.halted, ifA.stall_cycles});
        if (qB.size() > 0)
            compare("dutB", qB.pop_front(),
                    {ifB.issue, ifB.stall, ifB.inject_nop, ifB.halted, ifB.stall_cycles});
    end

    task automatic step(
        input bit sel, input logic rstV, input logic v,
        input logic [2:0] rs, input logic rsu, input logic [2:0] rt, input logic rtu,
        input logic [2:0] wr, input logic wre,
        input logic isLd, input logic isCtrl, input logic isHalt,
        input logic eIssue, input logic eStall, input logic eHalted, input logic [15:0] eCyc);
        exp_t e;
        @(posedge clk);
        #1;
        rst = rstV;
        if (!sel) begin
            ifA.dec_valid = v;    ifA.dec_rs_idx = rs; ifA.dec_rs_use = rsu;
            ifA.dec_rt_idx = rt;  ifA.dec_rt_use = rtu;
            ifA.dec_wr_idx = wr;  ifA.dec_wr_en = wre;
            ifA.dec_is_load = isLd; ifA.dec_is_ctrl = isCtrl; ifA.dec_is_halt = isHalt;
        end else begin
            ifB.dec_valid = v;    ifB.dec_rs_idx = rs; ifB.dec_rs_use = rsu;
            ifB.dec_rt_idx = rt;  ifB.dec_rt_use = rtu;
            ifB.dec_wr_idx = wr;  ifB.dec_wr_en = wre;
            ifB.dec_is_load = isLd; ifB.dec_is_ctrl = isCtrl; ifB.dec_is_halt = isHalt;
        end
        stepId++;
        e.id = stepId;
        e.v  = {eIssue, eStall, ~eIssue, eHalted, eCyc};
        if (!sel) qA.push_back(e);
        else      qB.push_back(e);
    endtask

    initial begin
        ifA.dec_valid = 0; ifA.dec_rs_idx = 0; ifA.dec_rs_use = 0; ifA.dec_rt_idx = 0;
        ifA.dec_rt_use = 0; ifA.dec_wr_idx = 0; ifA.dec_wr_en = 0; ifA.dec_is_load = 0;
        ifA.dec_is_ctrl = 0; ifA.dec_is_halt = 0;
        ifB.dec_valid = 0; ifB.dec_rs_idx = 0; ifB.dec_rs_use = 0; ifB.dec_rt_idx = 0;
        ifB.dec_rt_use = 0; ifB.dec_wr_idx = 0; ifB.dec_wr_en = 0; ifB.dec_is_load = 0;
        ifB.dec_is_ctrl = 0; ifB.dec_is_halt = 0;

        // ---------------- FWD_EN=0, WB_LAT=3, CTRL_SHADOW=4 ----------------
        // reset state
        step(0, 0, 0, 0,0, 0,0, 0,0, 0,0,0,  0,0,0, 0);
        step(0, 0, 1, 0,0, 0,0, 0,0, 0,0,0,  1,0,0, 0);
        // ADD r1 then SUB reading r1: three stall cycles
        step(0, 1, 1, 5,1, 6,1, 1,1, 0,0,0,  1,0,0, 0);
        step(0, 1, 1, 1,1, 0,1, 4,1, 0,0,0,  0,1,0, 0);
        step(0, 1, 1, 1,1, 0,1, 4,1, 0,0,0,  0,1,0, 1);
        step(0, 1, 1, 1,1, 0,1, 4,1, 0,0,0,  0,1,0, 2);
        step(0, 1, 1, 1,1, 0,1, 4,1, 0,0,0,  1,0,0, 3);
        step(0, 1, 0, 0,0, 0,0, 0,0, 0,0,0,  0,0,0, 3);
        // BEQZ then non-dependent instruction: shadow of four
        step(0, 1, 1, 5,1, 0,0, 0,0, 0,1,0,  1,0,0, 3);
        step(0, 1, 1, 6,1, 6,1, 7,1, 0,0,0,  0,1,0, 3);
        step(0, 1, 1, 6,1, 6,1, 7,1, 0,0,0,  0,1,0, 4);
        step(0, 1, 1, 6,1, 6,1, 7,1, 0,0,0,  0,1,0, 5);
        step(0, 1, 1, 6,1, 6,1, 7,1, 0,0,0,  0,1,0, 6);
        step(0, 1, 1, 6,1, 6,1, 7,1, 0,0,0,  1,0,0, 7);
        // WAW + self-dependence: ADD r3 ; ADD r3,r3 ; then an rt reader of r3
        step(0, 1, 1, 5,1, 6,1, 3,1, 0,0,0,  1,0,0, 7);
        step(0, 1, 1, 3,1, 6,1, 3,1, 0,0,0,  0,1,0, 7);
        step(0, 1, 1, 3,1, 6,1, 3,1, 0,0,0,  0,1,0, 8);
        step(0, 1, 1, 3,1, 6,1, 3,1, 0,0,0,  0,1,0, 9);
        step(0, 1, 1, 3,1, 6,1, 3,1, 0,0,0,  1,0,0, 10);
        step(0, 1, 1, 6,1, 3,1, 0,0, 0,0,0,  0,1,0, 10);
        step(0, 1, 1, 6,1, 3,1, 0,0, 0,0,0,  0,1,0, 11);
        step(0, 1, 1, 6,1, 3,1, 0,0, 0,0,0,  0,1,0, 12);
        step(0, 1, 1, 6,1, 3,1, 0,0, 0,0,0,  1,0,0, 13);
        // RAW overlapping a control shadow: counted once per cycle
        step(0, 1, 1, 5,1, 6,1, 2,1, 0,0,0,  1,0,0, 13);
        step(0, 1, 1, 6,1, 0,0, 0,0, 0,1,0,  1,0,0, 13);
        step(0, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  0,1,0, 13);
        step(0, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  0,1,0, 14);
        step(0, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  0,1,0, 15);
        step(0, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  0,1,0, 16);
        step(0, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  1,0,0, 17);
        // HALT: later instructions stall, counter frozen; async reset releases
        step(0, 1, 1, 5,1, 6,1, 1,1, 0,0,0,  1,0,0, 17);
        step(0, 1, 1, 0,0, 0,0, 0,0, 0,0,1,  1,0,0, 17);
        step(0, 1, 1, 1,1, 0,0, 4,1, 0,0,0,  0,1,1, 17);
        step(0, 1, 1, 1,1, 0,0, 4,1, 0,0,0,  0,1,1, 17);
        step(0, 0, 1, 1,1, 0,0, 4,1, 0,0,0,  1,0,0, 0);
        // async reset during a RAW stall
        step(0, 1, 1, 5,1, 6,1, 1,1, 0,0,0,  1,0,0, 0);
        step(0, 1, 1, 1,1, 0,0, 4,1, 0,0,0,  0,1,0, 0);
        step(0, 0, 1, 1,1, 0,0, 4,1, 0,0,0,  1,0,0, 0);
        step(0, 1, 1, 1,1, 0,0, 4,1, 0,0,0,  1,0,0, 0);
        step(0, 1, 0, 0,0, 0,0, 0,0, 0,0,0,  0,0,0, 0);

        // ---------------- FWD_EN=1, WB_LAT=3 ----------------
        step(1, 0, 0, 0,0, 0,0, 0,0, 0,0,0,  0,0,0, 0);
        // ALU producer forwards with no penalty
        step(1, 1, 1, 5,1, 6,1, 2,1, 0,0,0,  1,0,0, 0);
        step(1, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  1,0,0, 0);
        // load producer: one bubble (rs path, after a WAW reload of r2)
        step(1, 1, 1, 7,1, 0,0, 2,1, 1,0,0,  1,0,0, 0);
        step(1, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  0,1,0, 0);
        step(1, 1, 1, 2,1, 0,0, 4,1, 0,0,0,  1,0,0, 1);
        // load producer: one bubble (rt path, store data)
        step(1, 1, 1, 7,1, 0,0, 5,1, 1,0,0,  1,0,0, 1);
        step(1, 1, 1, 6,1, 5,1, 0,0, 0,0,0,  0,1,0, 1);
        step(1, 1, 1, 6,1, 5,1, 0,0, 0,0,0,  1,0,0, 2);
        step(1, 1, 0, 0,0, 0,0, 0,0, 0,0,0,  0,0,0, 2);

        repeat (3) @(posedge clk);
        nChecks++;
        if (qA.size() != 0 || qB.size() != 0) begin
            nFail++;
            $display("FAIL drain: %0d/%0d expected records never checked, required 0/0",
                     qA.size(), qB.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
